left_shift_seq: RTL and testbench

Multi-cycle logical left shifter for the ALU shift path; complements the combinational arithmetic right shifter. It accepts a 32-bit operand and 5-bit shift amount through a start/ready handshake and shifts iteratively in a registered datapath. It raises a one-cycle result strobe and holds the result until the next result completes. It trades latency for area in the multi-cycle execute stage.

---
 rtl/left_shift_seq.sv | 154 +++++++++++++++
 tb/tb_left_shift_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/left_shift_seq.sv
// Multi-cycle logical left shifter, start/ready handshake, registered result.
// Define LSHIFT_STAGED_EN for a fixed 5-stage log shifter instead of 1 bit/cycle.
module left_shift_seq (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] opA,
    input  logic [4:0]  amt,
    output logic        ready,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] cout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] shreg_q, shreg_d;
    logic [31:0] cout_q,  cout_d;

`ifdef LSHIFT_STAGED_EN
    logic [2:0]  stage_q, stage_d;
    logic [4:0]  amt_q,   amt_d;
    logic [31:0] stage_val;

    // Stage k conditionally shifts by 2^k depending on bit k of the amount
    always_comb begin
        stage_val = shreg_q;
        unique case (stage_q)
            3'd0:    if (amt_q[0]) stage_val = shreg_q << 1;
            3'd1:    if (amt_q[1]) stage_val = shreg_q << 2;
            3'd2:    if (amt_q[2]) stage_val = shreg_q << 4;
            3'd3:    if (amt_q[3]) stage_val = shreg_q << 8;
            default: if (amt_q[4]) stage_val = shreg_q << 16;
        endcase
    end

    // Next-state and datapath updates for the staged build
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cout_d  = cout_q;
        stage_d = stage_q;
        amt_d   = amt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = opA;
                    amt_d   = amt;
                    stage_d = 3'd0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d = stage_val;
                stage_d = stage_q + 3'd1;
                if (stage_q == 3'd4) begin
                    cout_d  = stage_val;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= 32'h0;
            cout_q  <= 32'h0;
            stage_q <= 3'd0;
            amt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cout_q  <= cout_d;
            stage_q <= stage_d;
            amt_q   <= amt_d;
        end
    end
`else
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] shl1;

    assign shl1 = {shreg_q[30:0], 1'b0};

    // Next-state and datapath updates, one bit per SHIFT cycle
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d = opA;
                    cnt_d   = amt;
                    if (amt == 5'd0) begin
                        cout_d  = opA;
                        state_d = DONE;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                shreg_d = shl1;
                cnt_d   = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    cout_d  = shl1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= 32'h0;
            cout_q  <= 32'h0;
            cnt_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end
`endif

    assign ready        = (state_q == IDLE);
    assign busy         = ~ready;
    assign result_valid = (state_q == DONE);
    assign cout         = cout_q;

endmodule

// File: tb/tb_left_shift_seq.sv
// Directed bench for left_shift_seq: vector table plus handshake corner cases.
// Latency expectations follow LSHIFT_STAGED_EN when it is defined.
module tb_left_shift_seq;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] opA;
    logic [4:0]  amt;
    logic        ready;
    logic        busy;
    logic        result_valid;
    logic [31:0] cout;

    int checks = 0;
    int errors = 0;

    left_shift_seq dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .opA          (opA),
        .amt          (amt),
        .ready        (ready),
        .busy         (busy),
        .result_valid (result_valid),
        .cout         (cout)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [4:0]  m;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int lat_of(input logic [4:0] m);
`ifdef LSHIFT_STAGED_EN
        return 6;
`else
        return int'(m) + 1;
`endif
    endfunction

    // Called at a negedge with ready high; returns at the negedge where ready rises again
    task automatic run_op(input logic [31:0] a, input logic [4:0] m,
                          output int rv_cyc, output int npulse,
                          output int rdy_cyc, output logic [31:0] c_rv);
        int cyc;
        start = 1'b1;
        opA   = a;
        amt   = m;
        @(negedge clock);
        start   = 1'b0;
        opA     = $urandom;
        amt     = 5'($urandom);
        cyc     = 1;
        rv_cyc  = -1;
        npulse  = 0;
        rdy_cyc = -1;
        c_rv    = 32'hx;
        while (cyc < 64) begin
            if (result_valid) begin
                npulse++;
                if (rv_cyc < 0) begin
                    rv_cyc = cyc;
                    c_rv   = cout;
                end
            end
            if (ready) begin
                rdy_cyc = cyc;
                break;
            end
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        int          rv_cyc, npulse, rdy_cyc, lat, rcyc, n;
        int          rv1, rv2;
        logic [31:0] c_rv;
        string       tag;

        vecs[0] = '{32'h0000_0001, 5'd5,  32'h0000_0020};
        vecs[1] = '{32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[2] = '{32'hFFFF_FFFF, 5'd31, 32'h8000_0000};
        vecs[3] = '{32'h8000_0001, 5'd4,  32'h0000_0010};
        vecs[4] = '{32'h0000_0003, 5'd2,  32'h0000_000C};
        vecs[5] = '{32'h1234_5678, 5'd16, 32'h5678_0000};
        vecs[6] = '{32'hA5A5_A5A5, 5'd1,  32'h4B4B_4B4A};

        reset = 1'b1;
        start = 1'b0;
        opA   = 32'h0;
        amt   = 5'd0;
        repeat (3) @(negedge clock);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_rv",    32'(result_valid), 32'd0);
        chk("rst_cout",  cout, 32'h0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven single operations
        foreach (vecs[i]) begin
            lat = lat_of(vecs[i].m);
            run_op(vecs[i].a, vecs[i].m, rv_cyc, npulse, rdy_cyc, c_rv);
            tag = $sformatf("v%0d", i);
            chk({tag, "_rvcyc"}, 32'(rv_cyc), 32'(lat));
            chk({tag, "_npulse"}, 32'(npulse), 32'd1);
            chk({tag, "_rdycyc"}, 32'(rdy_cyc), 32'(lat + 1));
            chk({tag, "_cout_rv"}, c_rv, vecs[i].exp);
            chk({tag, "_cout_hold"}, cout, vecs[i].exp);
        end

        // Start pulses while busy and in DONE are ignored
        lat = lat_of(5'd8);
        start = 1'b1;
        opA   = 32'h0000_00FF;
        amt   = 5'd8;
        n = 0;
        rv1 = -1;
        rdy_cyc = -1;
        for (int c = 1; c < 64; c++) begin
            @(negedge clock);
            if (result_valid) begin
                n++;
                if (rv1 < 0) rv1 = c;
            end
            if (ready) begin
                rdy_cyc = c;
                start = 1'b0;
                break;
            end
            start = (c == 3 || c == lat);
            opA   = 32'h1;
            amt   = 5'd1;
        end
        chk("ign_npulse", 32'(n), 32'd1);
        chk("ign_rvcyc", 32'(rv1), 32'(lat));
        chk("ign_rdycyc", 32'(rdy_cyc), 32'(lat + 1));
        chk("ign_cout", cout, 32'h0000_FF00);
        repeat (2) @(negedge clock);
        chk("ign_idle_ready", 32'(ready), 32'd1);
        chk("ign_idle_rv", 32'(result_valid), 32'd0);
        chk("ign_cout_hold", cout, 32'h0000_FF00);

        // Reset mid-operation drops the result
`ifdef LSHIFT_STAGED_EN
        rcyc = 3;
`else
        rcyc = 10;
`endif
        start = 1'b1;
        opA   = 32'h1;
        amt   = 5'd20;
        n = 0;
        for (int c = 1; c <= rcyc; c++) begin
            @(negedge clock);
            start = 1'b0;
            if (result_valid) n++;
        end
        chk("mid_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        start = 1'b1;
        #1;
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_cout", cout, 32'h0);
        chk("mid_rv", 32'(result_valid | (n != 0)), 32'd0);
        @(negedge clock);
        chk("mid_start_ign", 32'(busy), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        lat = lat_of(5'd2);
        run_op(32'h3, 5'd2, rv_cyc, npulse, rdy_cyc, c_rv);
        chk("post_rvcyc", 32'(rv_cyc), 32'(lat));
        chk("post_cout", c_rv, 32'h0000_000C);

        // Back-to-back with start held high
        lat = lat_of(5'd3);
        start = 1'b1;
        opA   = 32'h1;
        amt   = 5'd3;
        n = 0;
        rv1 = -1;
        rv2 = -1;
        for (int c = 1; c <= 2 * lat + 1; c++) begin
            @(negedge clock);
            if (result_valid) begin
                n++;
                if (rv1 < 0) rv1 = c;
                else rv2 = c;
                chk($sformatf("b2b_cout_c%0d", c), cout, 32'h0000_0008);
            end
            if (c == lat + 1)
                chk("b2b_ready2", 32'(ready), 32'd1);
        end
        start = 1'b0;
        chk("b2b_npulse", 32'(n), 32'd2);
        chk("b2b_rv1", 32'(rv1), 32'(lat));
        chk("b2b_rv2", 32'(rv2), 32'(2 * lat + 1));
        @(negedge clock);
        chk("b2b_final_ready", 32'(ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
